fifo_byte_drain: RTL and testbench

Read-side consumer for the team's 16-bit FIFO, running in the FIFO's read-clock domain. It pops 16-bit words through the FIFO read port (`r_en` / `empty` / `data_out`) and serialises each word into two bytes on a valid/ready byte stream toward the byte-wide link logic. It never issues a read against an empty FIFO and never drops or duplicates a word.

---
 rtl/fifo_drain_pkg.sv | 15 +
 rtl/fifo_byte_drain.sv | 100 ++++++++++
 tb/tb_fifo_byte_drain.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types and widths for the FIFO byte drain.
// Holds the drain FSM state encoding and the word/byte widths.
package fifo_drain_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HI      = 2'd2,
        LO      = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_byte_drain.sv
// fifo_byte_drain: pops 16-bit words from a FIFO read port and sends
// each as two bytes on a valid/ready stream, counting accepted bytes.
// Ports:
//   clk, rst                 read-side clock, sync active-high reset
//   empty, rd_data, r_en     FIFO read port (r_en combinational)
//   byte_out, byte_valid     byte stream toward the link logic
//   byte_ready               consumer accept
//   bytes_sent               accepted-byte count, wraps mod 2^CNT_W
module fifo_byte_drain
    import fifo_drain_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    input  logic [WORD_W-1:0] rd_data,
    output logic              r_en,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic [CNT_W-1:0]  bytes_sent
);

    if (WORD_W != 2 * BYTE_W) begin : g_width_chk
        $error("WORD_W must be twice BYTE_W");
    end

    state_t            state;
    state_t            state_nx;
    logic [WORD_W-1:0] wbuf;
    logic [BYTE_W-1:0] first_byte;
    logic [BYTE_W-1:0] second_byte;

    assign first_byte  = MSB_FIRST ? wbuf[WORD_W-1:BYTE_W]
                                   : wbuf[BYTE_W-1:0];
    assign second_byte = MSB_FIRST ? wbuf[BYTE_W-1:0]
                                   : wbuf[WORD_W-1:BYTE_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wbuf       <= '0;
            bytes_sent <= '0;
        end else begin
            state <= state_nx;
            if (state == CAPTURE) begin
                wbuf <= rd_data;
            end
            if (byte_valid && byte_ready) begin
                bytes_sent <= bytes_sent + CNT_W'(1);
            end
        end
    end

    // Outputs are forced idle while rst is high so nothing leaks out of
    // a state that is about to be discarded.
    always_comb begin
        state_nx   = state;
        r_en       = 1'b0;
        byte_valid = 1'b0;
        byte_out   = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    r_en = ~empty;
                    if (!empty) begin
                        state_nx = CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_nx = HI;
                end
                HI: begin
                    byte_valid = 1'b1;
                    byte_out   = first_byte;
                    if (byte_ready) begin
                        state_nx = LO;
                    end
                end
                LO: begin
                    byte_valid = 1'b1;
                    byte_out   = second_byte;
                    // Prefetch the next word as the last byte leaves so
                    // a full FIFO streams 2 bytes every 3 cycles.
                    if (byte_ready) begin
                        if (!empty) begin
                            r_en     = 1'b1;
                            state_nx = CAPTURE;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_drain.sv
// tb_fifo_byte_drain: scoreboard bench for fifo_byte_drain.
// Three instances (MSB first, LSB first, 4-bit counter) share stimulus.
module tb_fifo_byte_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        empty;
    logic [15:0] rd_data;
    logic        byte_ready;

    logic        r_en_a, r_en_b, r_en_c;
    logic [7:0]  byte_out_a, byte_out_b, byte_out_c;
    logic        byte_valid_a, byte_valid_b, byte_valid_c;
    logic [15:0] bytes_sent_a, bytes_sent_b;
    logic [3:0]  bytes_sent_c;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int feed_pct = 100;

    logic [15:0] fifo_q[$];
    logic [15:0] stage_q[$];
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    int          ren_cyc_q[$];
    int          acc_cyc_q[$];
    logic        pop_pending = 1'b0;
    logic [15:0] ref_a = '0;
    logic [3:0]  ref_c = '0;
    logic        hold_prev = 1'b0;
    logic [7:0]  prev_byte = '0;

    always #5 clk = ~clk;

    fifo_byte_drain #(.MSB_FIRST(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .empty(empty), .rd_data(rd_data),
        .r_en(r_en_a), .byte_out(byte_out_a),
        .byte_valid(byte_valid_a), .byte_ready(byte_ready),
        .bytes_sent(bytes_sent_a)
    );

    fifo_byte_drain #(.MSB_FIRST(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .empty(empty), .rd_data(rd_data),
        .r_en(r_en_b), .byte_out(byte_out_b),
        .byte_valid(byte_valid_b), .byte_ready(byte_ready),
        .bytes_sent(bytes_sent_b)
    );

    fifo_byte_drain #(.MSB_FIRST(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .empty(empty), .rd_data(rd_data),
        .r_en(r_en_c), .byte_out(byte_out_c),
        .byte_valid(byte_valid_c), .byte_ready(byte_ready),
        .bytes_sent(bytes_sent_c)
    );

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Monitor and FIFO read model: everything sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc = cyc + 1;
        chk("ren_empty", 32'(r_en_a & empty), 32'd0);
        chk("ren_lsb", 32'(r_en_b), 32'(r_en_a));
        chk("ren_w4", 32'(r_en_c), 32'(r_en_a));
        chk("valid_lsb", 32'(byte_valid_b), 32'(byte_valid_a));
        chk("valid_w4", 32'(byte_valid_c), 32'(byte_valid_a));
        chk("byte_w4", 32'(byte_out_c), 32'(byte_out_a));
        chk("cnt", 32'(bytes_sent_a), 32'(ref_a));
        chk("cnt_lsb", 32'(bytes_sent_b), 32'(ref_a));
        chk("cnt_w4", 32'(bytes_sent_c), 32'(ref_c));
        if (hold_prev && !rst) begin
            chk("hold_valid", 32'(byte_valid_a), 32'd1);
            chk("hold_byte", 32'(byte_out_a), 32'(prev_byte));
        end
        if (rst) begin
            chk("rst_valid", 32'(byte_valid_a), 32'd0);
            chk("rst_ren", 32'(r_en_a), 32'd0);
            chk("rst_byte", 32'(byte_out_a), 32'd0);
            ref_a = '0;
            ref_c = '0;
        end else begin
            if (r_en_a) begin
                ren_cyc_q.push_back(cyc);
                if (!empty) pop_pending = 1'b1;
            end
            if (byte_valid_a && byte_ready) begin
                acc_cyc_q.push_back(cyc);
                if (exp_a.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_byte: got %0h, none expected",
                             byte_out_a);
                end else begin
                    e = exp_a.pop_front();
                    chk("byte_msb", 32'(byte_out_a), 32'(e));
                    e = exp_b.pop_front();
                    chk("byte_lsb", 32'(byte_out_b), 32'(e));
                end
                ref_a = ref_a + 16'd1;
                ref_c = ref_c + 4'd1;
            end
        end
        hold_prev = !rst && byte_valid_a && !byte_ready;
        prev_byte = byte_out_a;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_pending) begin
            rd_data     = fifo_q.pop_front();
            pop_pending = 1'b0;
        end
        if (stage_q.size() > 0 && $urandom_range(99) < feed_pct)
            fifo_q.push_back(stage_q.pop_front());
        empty = (fifo_q.size() == 0);
    endtask

    task automatic expect_word(logic [15:0] w);
        exp_a.push_back(w[15:8]);
        exp_a.push_back(w[7:0]);
        exp_b.push_back(w[7:0]);
        exp_b.push_back(w[15:8]);
    endtask

    task automatic load_word(logic [15:0] w);
        fifo_q.push_back(w);
        expect_word(w);
        empty = 1'b0;
    endtask

    task automatic push_word(logic [15:0] w);
        stage_q.push_back(w);
        expect_word(w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_q.delete();
        stage_q.delete();
        exp_a.delete();
        exp_b.delete();
        pop_pending = 1'b0;
        empty       = 1'b1;
        rd_data     = '0;
        step();
        rst = 1'b0;
        ren_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((exp_a.size() != 0 || stage_q.size() != 0)
               && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 32'(exp_a.size()), 32'd0);
        repeat (3) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pushed;
        rst        = 1'b1;
        empty      = 1'b1;
        rd_data    = '0;
        byte_ready = 1'b0;
        step();
        do_reset();
        @(negedge clk);
        chk("reset_valid", 32'(byte_valid_a), 32'd0);
        chk("reset_ren", 32'(r_en_a), 32'd0);
        chk("reset_byte", 32'(byte_out_a), 32'd0);
        chk("reset_cnt", 32'(bytes_sent_a), 32'd0);

        // Single word
        byte_ready = 1'b1;
        step();
        load_word(16'hA55A);
        drain(50);
        chk("single_ren", 32'(ren_cyc_q.size()), 32'd1);
        chk("single_acc", 32'(acc_cyc_q.size()), 32'd2);
        if (ren_cyc_q.size() >= 1 && acc_cyc_q.size() >= 2) begin
            chk("single_lat", 32'(acc_cyc_q[0] - ren_cyc_q[0]), 32'd2);
            chk("single_gap", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd1);
        end
        chk("single_cnt", 32'(bytes_sent_a), 32'd2);
        chk("single_idle", 32'({byte_valid_a, r_en_a}), 32'd0);

        // Backpressure
        do_reset();
        byte_ready = 1'b0;
        load_word(16'h1234);
        n = 0;
        while (!byte_valid_a && n < 10) begin
            step();
            n++;
        end
        chk("bp_reach_hi", 32'(byte_valid_a), 32'd1);
        repeat (5) step();
        chk("bp_hi_byte", 32'(byte_out_a), 32'h12);
        byte_ready = 1'b1;
        step();
        byte_ready = 1'b0;
        repeat (5) step();
        chk("bp_lo_byte", 32'(byte_out_a), 32'h34);
        chk("bp_lo_valid", 32'(byte_valid_a), 32'd1);
        byte_ready = 1'b1;
        drain(50);
        chk("bp_ren", 32'(ren_cyc_q.size()), 32'd1);
        chk("bp_acc", 32'(acc_cyc_q.size()), 32'd2);

        // Streaming: 4 words back-to-back
        do_reset();
        byte_ready = 1'b1;
        for (int i = 1; i <= 4; i++) load_word(16'(i));
        drain(60);
        chk("stream_ren", 32'(ren_cyc_q.size()), 32'd4);
        chk("stream_acc", 32'(acc_cyc_q.size()), 32'd8);
        if (ren_cyc_q.size() >= 1 && acc_cyc_q.size() >= 8) begin
            chk("stream_lat", 32'(acc_cyc_q[0] - ren_cyc_q[0]), 32'd2);
            chk("stream_span", 32'(acc_cyc_q[7] - ren_cyc_q[0]),
                32'd12);
        end

        // Reset mid-word while holding in LO
        do_reset();
        byte_ready = 1'b1;
        load_word(16'h1111);
        n = 0;
        while (acc_cyc_q.size() == 0 && n < 10) begin
            step();
            n++;
        end
        byte_ready = 1'b0;
        chk("mid_first_acc", 32'(acc_cyc_q.size()), 32'd1);
        repeat (2) step();
        chk("mid_in_lo", 32'(byte_out_a), 32'h11);
        do_reset();
        @(negedge clk);
        chk("mid_valid", 32'(byte_valid_a), 32'd0);
        chk("mid_cnt", 32'(bytes_sent_a), 32'd0);
        chk("mid_ren", 32'(r_en_a), 32'd0);
        byte_ready = 1'b1;
        step();
        load_word(16'hBEEF);
        drain(50);
        chk("mid_after_cnt", 32'(bytes_sent_a), 32'd2);

        // Counter wrap on the 4-bit instance
        do_reset();
        byte_ready = 1'b1;
        for (int i = 0; i < 9; i++) push_word(16'($urandom));
        drain(200);
        chk("wrap_cnt_w4", 32'(bytes_sent_c), 32'd2);
        chk("wrap_cnt", 32'(bytes_sent_a), 32'd18);

        // Randomized traffic with stalls on both sides
        do_reset();
        feed_pct = 40;
        pushed   = 0;
        n        = 0;
        while (pushed < 60 && n < 3000) begin
            if ($urandom_range(1) == 1) begin
                push_word(16'($urandom));
                pushed++;
            end
            byte_ready = ($urandom_range(3) != 0);
            step();
            n++;
        end
        byte_ready = 1'b1;
        feed_pct   = 100;
        drain(1000);
        chk("rand_cnt", 32'(bytes_sent_a), 32'(2 * pushed));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
